psum_accum_buffer: RTL

PSUM_ACCUM_BUFFER -- requirements
Module: psum_accum_buffer

---
 rtl/psum_accum_buffer_pkg.sv | 19 +
 rtl/psum_accum_buffer_sat_add16.sv | 24 ++
 rtl/psum_accum_buffer.sv | 112 +++++++++++
 3 files changed

// File: rtl/psum_accum_buffer_pkg.sv
// Shared types for the partial-sum accumulation buffer: psum width, psum
// value type, saturation limits and the controller state encoding.
package psum_accum_buffer_pkg;

    localparam int PSUM_DATA_SIZE = 16;

    typedef logic signed [PSUM_DATA_SIZE-1:0] psum_t;

    localparam psum_t PSUM_MAX = 16'sh7fff;
    localparam psum_t PSUM_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_DONE
    } ACC_STATE;

endpackage

// File: rtl/psum_accum_buffer_sat_add16.sv
// Signed 16-bit saturating adder. On overflow the sum clamps to the nearest
// representable extreme and overflow is flagged.
module sat_add16
    import psum_accum_buffer_pkg::*;
(
    input  psum_t a,
    input  psum_t b,
    output psum_t sum,
    output logic  overflow
);

    logic [PSUM_DATA_SIZE:0] w_wide;

    // One guard bit: overflow shows up as the guard bit disagreeing with the sign bit.
    assign w_wide   = {a[PSUM_DATA_SIZE-1], a} + {b[PSUM_DATA_SIZE-1], b};
    assign overflow = w_wide[PSUM_DATA_SIZE] != w_wide[PSUM_DATA_SIZE-1];

    always_comb begin
        sum = psum_t'(w_wide[PSUM_DATA_SIZE-1:0]);
        if (overflow)
            sum = w_wide[PSUM_DATA_SIZE] ? PSUM_MIN : PSUM_MAX;
    end

endmodule

// File: rtl/psum_accum_buffer.sv
// Accumulates OFMAP_W psums over num_rounds rounds from a PE column, then
// drains the results (optionally ReLU'd) to the global buffer.
module psum_accum_buffer
    import psum_accum_buffer_pkg::*;
#(
    parameter int OFMAP_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [3:0]                num_rounds,
    input  logic                      relu_en,
    input  logic [PSUM_DATA_SIZE-1:0] psum_in,
    input  logic                      psum_valid,
    output logic                      psum_ack,
    output logic [PSUM_DATA_SIZE-1:0] ofmap_data,
    output logic                      ofmap_valid,
    input  logic                      ofmap_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      sat
);

    localparam int             CW       = (OFMAP_W > 1) ? $clog2(OFMAP_W) : 1;
    localparam logic [CW-1:0]  LAST_COL = CW'(OFMAP_W - 1);

    ACC_STATE      r_state;
    logic [CW-1:0] r_col;
    logic [3:0]    r_round;
    logic [3:0]    r_last_round;
    logic          r_relu;
    logic          r_sat;
    psum_t         r_buf [OFMAP_W];

    psum_t w_cur;
    psum_t w_sum;
    logic  w_ovf;

    assign w_cur = r_buf[r_col];

    sat_add16 u_add (
        .a        (w_cur),
        .b        (psum_t'(psum_in)),
        .sum      (w_sum),
        .overflow (w_ovf)
    );

    assign psum_ack    = psum_valid && (r_state == ST_ACCUM);
    assign ofmap_valid = (r_state == ST_DRAIN);
    assign ofmap_data  = (r_relu && w_cur[PSUM_DATA_SIZE-1]) ? '0 : w_cur;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign sat         = r_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_round      <= '0;
            r_last_round <= '0;
            r_relu       <= 1'b0;
            r_sat        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_ACCUM;
                        // Zero rounds behaves as a single round.
                        r_last_round <= (num_rounds == 4'd0) ? 4'd0 : num_rounds - 4'd1;
                        r_relu       <= relu_en;
                        r_col        <= '0;
                        r_round      <= '0;
                        r_sat        <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (psum_valid) begin
                        if (w_ovf && r_round != 4'd0)
                            r_sat <= 1'b1;
                        if (r_col == LAST_COL) begin
                            r_col <= '0;
                            if (r_round == r_last_round)
                                r_state <= ST_DRAIN;
                            else
                                r_round <= r_round + 4'd1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (ofmap_ready) begin
                        if (r_col == LAST_COL) begin
                            r_col   <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Round 0 overwrites, so the buffer needs no clearing between jobs.
    always_ff @(posedge clk) begin
        if (psum_ack)
            r_buf[r_col] <= (r_round == 4'd0) ? psum_t'(psum_in) : w_sum;
    end

endmodule
